// File: rtl/palette_rgb_lut_pkg.sv
// palette_rgb_lut_pkg
// Purpose : shared colour-code names, default palette colours and the flash
//           FSM state type for the Space Invaders palette LUT.
// Ports   : none (package).
package palette_rgb_lut_pkg;

  // Colour codes produced by the sprite/priority mixer.
  localparam int BACKGROUND = 0;
  localparam int SPACESHIP  = 1;
  localparam int ALIENS0    = 2;
  localparam int ALIENS1    = 3;
  localparam int ALIENS2    = 4;
  localparam int ALIENS3    = 5;
  localparam int LASER      = 6;
  localparam int NONE       = 7;

  // Game default colours, RRRGGGBB.
  localparam logic [7:0] DEF_BACKGROUND = 8'h4D;
  localparam logic [7:0] DEF_SPACESHIP  = 8'h34;
  localparam logic [7:0] DEF_ALIENS0    = 8'h1E;
  localparam logic [7:0] DEF_ALIENS1    = 8'hD6;
  localparam logic [7:0] DEF_ALIENS2    = 8'h56;
  localparam logic [7:0] DEF_ALIENS3    = 8'h86;
  localparam logic [7:0] DEF_LASER      = 8'h80;
  localparam logic [7:0] DEF_NONE       = 8'h00;

  typedef enum logic {
    FLASH_OFF = 1'b0,
    FLASH_ON  = 1'b1
  } flash_state_e;

  // Reset colour of palette entry idx; entries beyond the named codes are black.
  function automatic logic [7:0] pal_default(input int idx);
    case (idx)
      BACKGROUND: return DEF_BACKGROUND;
      SPACESHIP:  return DEF_SPACESHIP;
      ALIENS0:    return DEF_ALIENS0;
      ALIENS1:    return DEF_ALIENS1;
      ALIENS2:    return DEF_ALIENS2;
      ALIENS3:    return DEF_ALIENS3;
      LASER:      return DEF_LASER;
      NONE:       return DEF_NONE;
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/palette_rgb_lut_flash_timer.sv
// palette_rgb_lut_flash_timer
// Purpose : frame-tick driven flash phase generator. The phase toggles every
//           FLASH_FRAMES frame ticks.
// Ports   : clk, rst (sync, active-high), frame_tick (1-cycle pulse per frame)
//           -> flash_phase (1 = ON).
//
//   state     | meaning
//   ----------+-------------------------------------------
//   FLASH_OFF | flashing entries show their palette colour
//   FLASH_ON  | flashing entries show FLASH_RGB
module palette_rgb_lut_flash_timer
  import palette_rgb_lut_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  output logic flash_phase
);

  localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  flash_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FLASH_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (frame_tick) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt = '0;
        case (r_state)
          FLASH_OFF: w_state_nxt = FLASH_ON;
          FLASH_ON:  w_state_nxt = FLASH_OFF;
          default:   w_state_nxt = FLASH_OFF;
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign flash_phase = (r_state == FLASH_ON);

endmodule

// File: rtl/palette_rgb_lut.sv
// palette_rgb_lut
// Purpose : writable colour-code -> RGB palette between the sprite mixer and
//           the VGA DAC. One-cycle registered lookup, blanking gate, per-entry
//           flash effect and write-first bypass on write/lookup collisions.
// Ports   : clk, rst (sync, active-high)
//           wr_en/wr_idx/wr_data  palette write port
//           flash_mask            bit i=1 makes entry i flash
//           frame_tick            one pulse per frame, paces the flash timer
//           pix_valid/pix_idx     lookup request, blank forces black
//           rgb/rgb_valid         registered colour to the DAC
//           flash_phase           current flash phase (1 = ON)
module palette_rgb_lut
  import palette_rgb_lut_pkg::*;
#(
  parameter int               IDX_W        = 3,
  parameter int               RGB_W        = 8,
  parameter int               FLASH_FRAMES = 8,
  parameter logic [RGB_W-1:0] FLASH_RGB    = RGB_W'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [RGB_W-1:0]      wr_data,
  input  logic [(2**IDX_W)-1:0] flash_mask,
  input  logic                  frame_tick,
  input  logic                  pix_valid,
  input  logic [IDX_W-1:0]      pix_idx,
  input  logic                  blank,
  output logic [RGB_W-1:0]      rgb,
  output logic                  rgb_valid,
  output logic                  flash_phase
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [RGB_W-1:0] r_pal [DEPTH];
  logic [RGB_W-1:0] r_rgb;
  logic             r_rgb_valid;

  logic             w_flash_phase;
  logic             w_hit;
  logic             w_flash;
  logic [RGB_W-1:0] w_entry;
  logic [RGB_W-1:0] w_rgb_nxt;

  palette_rgb_lut_flash_timer #(
    .FLASH_FRAMES (FLASH_FRAMES)
  ) u_flash_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .flash_phase (w_flash_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pal[i] <= RGB_W'(pal_default(i));
      end
    end else if (wr_en) begin
      r_pal[wr_idx] <= wr_data;
    end
  end

  // A write landing on the entry being looked up is forwarded so the DAC
  // sees the new colour in the same cycle it is written.
  assign w_hit   = wr_en && (wr_idx == pix_idx);
  assign w_entry = w_hit ? wr_data : r_pal[pix_idx];
  assign w_flash = w_flash_phase && flash_mask[pix_idx];

  always_comb begin
    w_rgb_nxt = '0;
    if (pix_valid && !blank) begin
      w_rgb_nxt = w_flash ? FLASH_RGB : w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb       <= w_rgb_nxt;
      r_rgb_valid <= pix_valid;
    end
  end

  assign rgb         = r_rgb;
  assign rgb_valid   = r_rgb_valid;
  assign flash_phase = w_flash_phase;

endmodule

// File: tb/tb_palette_rgb_lut.sv
module tb_palette_rgb_lut;

  localparam int FF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] flash_mask = 8'h40;
  logic       frame_tick = 1'b0;
  logic       pix_valid = 1'b0;
  logic [2:0] pix_idx = '0;
  logic       blank = 1'b0;
  logic [7:0] rgb;
  logic       rgb_valid;
  logic       flash_phase;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {rgb, rgb_valid} per driven cycle.
  logic [8:0] sb_q [$];

  // Reference model state.
  logic [7:0] defs [8] = '{8'h4D, 8'h34, 8'h1E, 8'hD6, 8'h56, 8'h86, 8'h80, 8'h00};
  logic [7:0] m_pal [8];
  logic       m_phase = 1'b0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  palette_rgb_lut #(
    .IDX_W        (3),
    .RGB_W        (8),
    .FLASH_FRAMES (FF),
    .FLASH_RGB    (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .flash_mask  (flash_mask),
    .frame_tick  (frame_tick),
    .pix_valid   (pix_valid),
    .pix_idx     (pix_idx),
    .blank       (blank),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .flash_phase (flash_phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, clock, compare output against scoreboard.
  task automatic cyc(input string tag, input logic r, input logic pv, input logic [2:0] idx,
                     input logic bl, input logic we, input logic [2:0] widx,
                     input logic [7:0] wd, input logic tk);
    logic [7:0] e_rgb;
    logic [8:0] e;
    rst = r; pix_valid = pv; pix_idx = idx; blank = bl;
    wr_en = we; wr_idx = widx; wr_data = wd; frame_tick = tk;
    if (r) e_rgb = 8'h00;
    else if (!pv || bl) e_rgb = 8'h00;
    else if (m_phase && flash_mask[idx]) e_rgb = 8'hFF;
    else if (we && widx == idx) e_rgb = wd;
    else e_rgb = m_pal[idx];
    sb_q.push_back({e_rgb, (r ? 1'b0 : pv)});
    if (r) begin
      for (int i = 0; i < 8; i++) m_pal[i] = defs[i];
      m_phase = 1'b0;
      m_cnt   = 0;
    end else begin
      if (we) m_pal[widx] = wd;
      if (tk) begin
        if (m_cnt == FF - 1) begin
          m_cnt   = 0;
          m_phase = ~m_phase;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".rgb"}, 32'(rgb), 32'(e[8:1]));
    chk({tag, ".valid"}, 32'(rgb_valid), 32'(e[0]));
    chk({tag, ".phase"}, 32'(flash_phase), 32'(m_phase));
  endtask

  initial begin
    // Reset beats a coincident write and frame tick.
    cyc("rst", 1, 1, 3'd0, 0, 1, 3'd0, 8'h11, 1);
    chk("rst_rgb0", 32'(rgb), 32'h0);
    chk("rst_phase0", 32'(flash_phase), 32'h0);
    cyc("rst2", 1, 0, 3'd0, 0, 0, 3'd0, 8'h00, 0);

    // Default palette, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      cyc("def", 0, 1, 3'(i), 0, 0, 3'd0, 8'h00, 0);
      chk("def_const", 32'(rgb), 32'(defs[i]));
    end

    // Blanking and invalid pixels.
    cyc("blank", 0, 1, 3'd3, 1, 0, 3'd0, 8'h00, 0);
    cyc("nopix", 0, 0, 3'd3, 0, 0, 3'd0, 8'h00, 0);

    // Write-first bypass, then persistence; other entries unchanged.
    cyc("bypass", 0, 1, 3'd2, 0, 1, 3'd2, 8'hE0, 0);
    chk("bypass_const", 32'(rgb), 32'hE0);
    for (int i = 0; i < 8; i++) cyc("after_wr", 0, 1, 3'(i), 0, 0, 3'd0, 8'h00, 0);

    // Flash: two ticks turn ON, two more turn OFF; entry 5 never flashes.
    cyc("tick1", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("tick2", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("on6", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 0);
    chk("on6_const", 32'(rgb), 32'hFF);
    chk("on_phase_const", 32'(flash_phase), 32'h1);
    cyc("on5", 0, 1, 3'd5, 0, 0, 3'd0, 8'h00, 0);
    cyc("on_blank6", 0, 1, 3'd6, 1, 0, 3'd0, 8'h00, 0);
    cyc("tick3", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("tick4", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("off6", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 0);
    chk("off6_const", 32'(rgb), 32'h80);
    chk("off_phase_const", 32'(flash_phase), 32'h0);

    // Back to ON, overwrite entry 1, then reset mid-frame.
    cyc("tick5", 0, 1, 3'd5, 0, 0, 3'd0, 8'h00, 1);
    cyc("tick6", 0, 1, 3'd5, 0, 1, 3'd1, 8'h00, 1);
    cyc("wr1chk", 0, 1, 3'd1, 0, 0, 3'd0, 8'h00, 0);
    cyc("midrst", 1, 1, 3'd6, 0, 0, 3'd0, 8'h00, 0);
    chk("midrst_rgb", 32'(rgb), 32'h0);
    chk("midrst_valid", 32'(rgb_valid), 32'h0);
    chk("midrst_phase", 32'(flash_phase), 32'h0);
    cyc("pal1_restored", 0, 1, 3'd1, 0, 0, 3'd0, 8'h00, 0);
    chk("pal1_const", 32'(rgb), 32'h34);

    // Counter was cleared: one tick is not enough, the second turns ON.
    cyc("rtick1", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("rchk1", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 0);
    cyc("rtick2", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 1);
    cyc("rchk2", 0, 1, 3'd6, 0, 0, 3'd0, 8'h00, 0);
    cyc("idle", 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
